// File: rtl/const_sched.sv
// rtl/const_sched.sv - constant ROM sequencer and round-robin arbiter; preload into RAM enabled by CONST_PRELOAD_EN
module const_sched #(
  parameter int RAM_AW   = 6,
  parameter int RAM_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              req0,
  input  logic              req1,
  input  logic [2:0]        sel0,
  input  logic [2:0]        sel1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              vld0,
  output logic              vld1,
  output logic              err,
  output logic [197:0]      data_out,
  output logic [5:0]        const_addr,
  input  logic [197:0]      const_out,
  input  logic              const_eff,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [197:0]      ram_wdata
);

  typedef enum logic [1:0] {IDLE, PRELOAD, ARB} state_t;

  state_t state;
  logic   ptr;
  logic   arb_ok;

  // Indices 0..4 map to one-hot ROM rows; 5..7 select the empty row 0.
  function automatic logic [5:0] idx2addr(input logic [2:0] idx);
    case (idx)
      3'd0:    idx2addr = 6'd1;
      3'd1:    idx2addr = 6'd2;
      3'd2:    idx2addr = 6'd4;
      3'd3:    idx2addr = 6'd8;
      3'd4:    idx2addr = 6'd16;
      default: idx2addr = 6'd0;
    endcase
  endfunction

  // Grants are only handed out outside preload, and never while reset holds.
  assign arb_ok = (state != PRELOAD) && !reset;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer's client.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_ok) begin
      if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
      else if (req1)               gnt1 = 1'b1;
    end
  end

  // Pointer moves to the client that did not just win; valids follow grants by one ROM cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= 1'b0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else begin
      vld0 <= gnt0;
      vld1 <= gnt1;
      if (gnt0)      ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
    end
  end

  assign err      = (vld0 | vld1) & ~const_eff;
  assign data_out = const_out;

`ifdef CONST_PRELOAD_EN
  logic [2:0] cnt;
  logic       issue;
  logic       tag_vld;
  logic [2:0] tag_idx;

  assign issue = (state == PRELOAD) && (cnt < 3'd5);

  // Preload issue takes the ROM port; otherwise the granted client's index drives it.
  always_comb begin
    const_addr = 6'd0;
    if (issue)     const_addr = idx2addr(cnt);
    else if (gnt0) const_addr = idx2addr(sel0);
    else if (gnt1) const_addr = idx2addr(sel1);
  end

  // Preload sequencer: walk indices 0..4, tag each issue so the next cycle writes the ROM data to RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      tag_vld <= 1'b0;
      tag_idx <= 3'd0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      tag_vld <= issue;
      if (issue) tag_idx <= cnt;
      case (state)
        IDLE, ARB: begin
          if (start) begin
            state <= PRELOAD;
            cnt   <= 3'd0;
          end
        end
        PRELOAD: begin
          if (cnt == 3'd5) begin
            state <= ARB;
            done  <= 1'b1;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == PRELOAD);
  assign ram_we    = tag_vld;
  assign ram_waddr = RAM_AW'(RAM_BASE) + RAM_AW'(tag_idx);
  assign ram_wdata = const_out;
`else
  logic unused_ok;

  // Arbitration only: the ROM port follows the granted client.
  always_comb begin
    const_addr = 6'd0;
    if (gnt0)      const_addr = idx2addr(sel0);
    else if (gnt1) const_addr = idx2addr(sel1);
  end

  assign state     = IDLE;
  assign busy      = 1'b0;
  assign done      = 1'b0;
  assign ram_we    = 1'b0;
  assign ram_waddr = '0;
  assign ram_wdata = '0;
  assign unused_ok = start ^ (^(RAM_AW'(RAM_BASE)));
`endif

endmodule
